crack_sched: RTL and testbench

- Parametrised key-space scheduler for the ARC4 brute-force cracker.
- Drives NCORES independent crack cores; the current task-level design hard-wires two. Each core is fed candidate keys in ascending order using the existing rdy/en protocol.
- Returns the smallest key any core reports as producing readable plaintext, or reports exhaustion if no core does.
- Sits between the task top level (KEY/HEX/LEDR glue) and the array of crack cores.

---
 rtl/crack_pkg.sv | 12 +
 rtl/crack_sched_lowest_set.sv | 23 ++
 rtl/crack_sched.sv | 163 ++++++++++++++++
 tb/tb_crack_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crack_pkg.sv
// Shared types and defaults for the ARC4 key-space scheduler.
package crack_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2
  } sched_state_t;

  localparam int CRACK_KEY_W = 24;

endpackage

// File: rtl/crack_sched_lowest_set.sv
// Find-first-set: index of the lowest set bit of vec, plus an any-set flag.
module lowest_set #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crack_sched.sv
// Key-space scheduler: hands ascending candidate keys to NCORES crack cores
// and keeps the smallest key any core reports as found.
module crack_sched
  import crack_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int KEY_W  = CRACK_KEY_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    rdy,
  output logic [NCORES-1:0]       core_en,
  output logic [NCORES*KEY_W-1:0] core_key,
  input  logic [NCORES-1:0]       core_rdy,
  input  logic [NCORES-1:0]       core_found,
  output logic [KEY_W-1:0]        key,
  output logic                    key_valid,
  output logic                    done,
  output logic [KEY_W:0]          keys_tried
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam logic [KEY_W:0] KT_MAX = {1'b1, {KEY_W{1'b0}}};

  sched_state_t              state_q, state_d;
  logic [KEY_W-1:0]          next_key_q, next_key_d;
  logic [NCORES-1:0]         busy_q, busy_d;
  logic [NCORES-1:0]         core_en_q, core_en_d;
  logic [NCORES-1:0]         en_dly_q;
  logic [NCORES*KEY_W-1:0]   core_key_q, core_key_d;
  logic [KEY_W-1:0]          key_q, key_d;
  logic                      found_q, found_d;
  logic                      key_valid_q, key_valid_d;
  logic                      done_q, done_d;
  logic [KEY_W:0]            kt_q, kt_d;

  logic [NCORES-1:0]         comp;
  logic [NCORES-1:0]         free;
  logic [IW-1:0]             pick_idx;
  logic                      pick_any;
  logic                      hit;
  logic [KEY_W-1:0]          hit_key;

  // A core is done when it is busy and ready again. The rdy seen while the
  // en pulse is out, and in the cycle right after it, is still the pre-start
  // value and must not count as a completion.
  assign comp = busy_q & core_rdy & ~core_en_q & ~en_dly_q;
  assign free = ~busy_q & core_rdy;

  lowest_set #(.N(NCORES), .IW(IW)) u_pick (
    .vec (free),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Smallest found key among this cycle's completions; strict < keeps the
  // lowest index on equal keys.
  always_comb begin
    hit     = 1'b0;
    hit_key = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (comp[i] && core_found[i] &&
          (!hit || core_key_q[i*KEY_W +: KEY_W] < hit_key)) begin
        hit     = 1'b1;
        hit_key = core_key_q[i*KEY_W +: KEY_W];
      end
    end
  end

  // Next-state: result merge, FSM, single dispatch per cycle.
  always_comb begin
    state_d     = state_q;
    next_key_d  = next_key_q;
    busy_d      = busy_q & ~comp;
    core_en_d   = '0;
    core_key_d  = core_key_q;
    key_d       = key_q;
    found_d     = found_q;
    key_valid_d = key_valid_q;
    done_d      = done_q;
    kt_d        = kt_q;

    if (hit && (!found_q || hit_key < key_q)) begin
      key_d   = hit_key;
      found_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          done_d      = 1'b0;
          key_valid_d = 1'b0;
          kt_d        = '0;
          found_d     = 1'b0;
          next_key_d  = '0;
          state_d     = DISPATCH;
        end
      end
      DISPATCH: begin
        if (hit || found_q) begin
          // Anything above a found key is pointless; let in-flight
          // smaller keys finish.
          state_d = DRAIN;
        end else if (pick_any) begin
          core_en_d[pick_idx]                  = 1'b1;
          core_key_d[pick_idx*KEY_W +: KEY_W]  = next_key_q;
          busy_d[pick_idx]                     = 1'b1;
          next_key_d                           = next_key_q + 1'b1;
          if (kt_q != KT_MAX) kt_d = kt_q + 1'b1;
          // Last key of the space issued: stop before next_key wraps to 0.
          if (next_key_q == '1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (busy_q == '0) begin
          done_d      = 1'b1;
          key_valid_d = found_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      next_key_q  <= '0;
      busy_q      <= '0;
      core_en_q   <= '0;
      en_dly_q    <= '0;
      core_key_q  <= '0;
      key_q       <= '0;
      found_q     <= 1'b0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      kt_q        <= '0;
    end else begin
      state_q     <= state_d;
      next_key_q  <= next_key_d;
      busy_q      <= busy_d;
      core_en_q   <= core_en_d;
      en_dly_q    <= core_en_q;
      core_key_q  <= core_key_d;
      key_q       <= key_d;
      found_q     <= found_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      kt_q        <= kt_d;
    end
  end

  assign rdy        = (state_q == IDLE);
  assign core_en    = core_en_q;
  assign core_key   = core_key_q;
  assign key        = key_q;
  assign key_valid  = key_valid_q;
  assign done       = done_q;
  assign keys_tried = kt_q;

endmodule

// File: tb/tb_crack_sched.sv
// Bench for crack_sched: behavioural mock cores with per-key latency and a
// found-key set; expected run results queued then compared when done rises.
module tb_crack_sched;

  localparam int NA = 4;
  localparam int KA = 8;
  localparam int NB = 3;
  localparam int KB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: 4 cores, 8-bit keys (cores can be masked off to act as fewer)
  logic              ena, rdya, kv_a, done_a;
  logic [NA-1:0]     core_en_a, core_rdy_a, core_found_a, ret_a, mask_a;
  logic [NA*KA-1:0]  core_key_a;
  logic [KA-1:0]     key_a;
  logic [KA:0]       kt_a;

  // DUT B: 3 cores, 4-bit keys
  logic              enb, rdyb, kv_b, done_b;
  logic [NB-1:0]     core_en_b, core_rdy_b, core_found_b, ret_b;
  logic [NB*KB-1:0]  core_key_b;
  logic [KB-1:0]     key_b;
  logic [KB:0]       kt_b;

  int lat_tab [256];
  bit fset    [256];

  crack_sched #(.NCORES(NA), .KEY_W(KA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(ena), .rdy(rdya),
    .core_en(core_en_a), .core_key(core_key_a), .core_rdy(core_rdy_a),
    .core_found(core_found_a), .key(key_a), .key_valid(kv_a),
    .done(done_a), .keys_tried(kt_a)
  );

  crack_sched #(.NCORES(NB), .KEY_W(KB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(enb), .rdy(rdyb),
    .core_en(core_en_b), .core_key(core_key_b), .core_rdy(core_rdy_b),
    .core_found(core_found_b), .key(key_b), .key_valid(kv_b),
    .done(done_b), .keys_tried(kt_b)
  );

  // Mock cores: rdy drops after en, returns after lat_tab[key] cycles.
  for (genvar g = 0; g < NA; g++) begin : g_mock_a
    logic r, rt;
    logic [KA-1:0] mk;
    int cnt;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r <= 1'b1; rt <= 1'b0; mk <= '0; cnt <= 0;
      end else begin
        rt <= 1'b0;
        if (r && core_en_a[g]) begin
          r   <= 1'b0;
          mk  <= core_key_a[g*KA +: KA];
          cnt <= lat_tab[core_key_a[g*KA +: KA]];
        end else if (!r) begin
          if (cnt <= 1) begin r <= 1'b1; rt <= 1'b1; end
          else cnt <= cnt - 1;
        end
      end
    end
    assign core_rdy_a[g]   = r & mask_a[g];
    assign core_found_a[g] = r & fset[mk];
    assign ret_a[g]        = rt;
  end

  for (genvar g = 0; g < NB; g++) begin : g_mock_b
    logic r, rt;
    logic [KB-1:0] mk;
    int cnt;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r <= 1'b1; rt <= 1'b0; mk <= '0; cnt <= 0;
      end else begin
        rt <= 1'b0;
        if (r && core_en_b[g]) begin
          r   <= 1'b0;
          mk  <= core_key_b[g*KB +: KB];
          cnt <= lat_tab[core_key_b[g*KB +: KB]];
        end else if (!r) begin
          if (cnt <= 1) begin r <= 1'b1; rt <= 1'b1; end
          else cnt <= cnt - 1;
        end
      end
    end
    assign core_rdy_b[g]   = r;
    assign core_found_b[g] = r & fset[mk];
    assign ret_b[g]        = rt;
  end

  // Dispatch monitor
  int cyc = 0;
  int first_a = -1;
  int fcyc = -1;
  int late_en = 0;
  int disp_b [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NA; i++)
      if (core_en_a[i] && first_a < 0) first_a = int'(core_key_a[i*KA +: KA]);
    if (fcyc < 0 && |(ret_a & core_found_a)) fcyc = cyc;
    if (fcyc >= 0 && cyc > fcyc && core_en_a != '0) late_en++;
    for (int i = 0; i < NB; i++)
      if (core_en_b[i]) disp_b[core_key_b[i*KB +: KB]]++;
  end

  // Checking and scoreboard
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string tag;
    int    sel;   // 0 key, 1 key_valid, 2 keys_tried
    int    val;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  function automatic int obs_of(input bit on_b, input int sel);
    case (sel)
      0:       return on_b ? int'(key_b) : int'(key_a);
      1:       return on_b ? int'(kv_b)  : int'(kv_a);
      default: return on_b ? int'(kt_b)  : int'(kt_a);
    endcase
  endfunction

  task automatic setup(input int lat);
    for (int i = 0; i < 256; i++) begin
      lat_tab[i] = lat;
      fset[i]    = 1'b0;
    end
  endtask

  task automatic pulse(input bit on_b);
    @(negedge clk);
    if (on_b) enb = 1'b1; else ena = 1'b1;
    @(negedge clk);
    enb = 1'b0; ena = 1'b0;
  endtask

  // Start a run, wait (bounded) for done, then compare queued expectations.
  task automatic go(input string name, input bit on_b);
    bit seen;
    exp_t e;
    pulse(on_b);
    chk({name, "_rdy_low"}, on_b ? int'(rdyb) : int'(rdya), 0);
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      seen = on_b ? done_b : done_a;
    end
    chk({name, "_done"}, int'(seen), 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs_of(on_b, e.sel), e.val);
    end
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; ena = 1'b0; enb = 1'b0; mask_a = '1;
    setup(20);
    for (int i = 0; i < 16; i++) disp_b[i] = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rdy",      int'(rdya), 1);
    chk("rst_core_en",  int'(core_en_a), 0);
    chk("rst_core_key", int'(core_key_a), 0);
    chk("rst_key",      int'(key_a), 0);
    chk("rst_kv",       int'(kv_a), 0);
    chk("rst_done",     int'(done_a), 0);
    chk("rst_kt",       int'(kt_a), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // 1: two cores, found {5}
    setup(20); fset[5] = 1'b1; mask_a = 4'b0011;
    fcyc = -1; late_en = 0;
    push("t1_key", 0, 5); push("t1_kv", 1, 1);
    go("t1", 1'b0);
    chk("t1_kt_range", int'(kt_a == 6 || kt_a == 7), 1);
    chk("t1_late_en", late_en, 0);

    // 2: four cores, found {3,6}; 6 reports first, 3 wins after drain
    setup(40); lat_tab[6] = 5; lat_tab[3] = 100;
    fset[3] = 1'b1; fset[6] = 1'b1; mask_a = 4'b1111;
    push("t2_key", 0, 3); push("t2_kv", 1, 1); push("t2_kt", 2, 7);
    go("t2", 1'b0);

    // 3: three cores, 4-bit keys, nothing found -> exhaust space
    setup(20);
    for (int i = 0; i < 16; i++) disp_b[i] = 0;
    push("t3_kv", 1, 0); push("t3_kt", 2, 16);
    go("t3", 1'b1);
    bad = 0;
    for (int i = 0; i < 16; i++) if (disp_b[i] != 1) bad++;
    chk("t3_each_once", bad, 0);
    chk("t3_key0_once", disp_b[0], 1);
    repeat (5) @(negedge clk);
    chk("t3_no_wrap", disp_b[0], 1);

    // 4: keys 8 and 9 complete in the same cycle, both found
    setup(20); lat_tab[8] = 21; fset[8] = 1'b1; fset[9] = 1'b1; mask_a = 4'b0011;
    push("t4_key", 0, 8); push("t4_kv", 1, 1); push("t4_kt", 2, 10);
    go("t4", 1'b0);

    // 5: en while busy ignored; reset mid-run aborts; restart from key 0
    setup(20); mask_a = 4'b0011;
    pulse(1'b0);
    repeat (8) @(negedge clk);
    chk("t5_kt_before", int'(kt_a), 2);
    pulse(1'b0);
    repeat (2) @(negedge clk);
    chk("t5_kt_ignored", int'(kt_a), 2);
    chk("t5_rdy_busy", int'(rdya), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rdy", int'(rdya), 1);
    chk("t5_rst_done", int'(done_a), 0);
    chk("t5_rst_kv", int'(kv_a), 0);
    chk("t5_rst_core_en", int'(core_en_a), 0);
    chk("t5_rst_kt", int'(kt_a), 0);
    @(negedge clk) rst_n = 1'b1;
    first_a = -1; fset[2] = 1'b1;
    push("t5_key", 0, 2); push("t5_kv", 1, 1); push("t5_kt", 2, 4);
    go("t5", 1'b0);
    chk("t5_first_key", first_a, 0);

    // 6: single core, found {0}
    setup(20); fset[0] = 1'b1; mask_a = 4'b0001;
    push("t6_key", 0, 0); push("t6_kv", 1, 1); push("t6_kt", 2, 1);
    go("t6", 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_done_held", int'(done_a), 1);
    chk("t6_rdy_idle", int'(rdya), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
